// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle MIPS sequencer and its datapath.
// The sequencer (master) receives the opcode, the ALU zero flag and the memory
// ready handshake. It drives every mux select and write enable, plus a debug
// view of its state.
interface multicycle_ctrl_if;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;

  logic       pc_en;
  logic       ir_write;
  logic       mem_write;
  logic       reg_write;
  logic       iord;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_src;
  logic       instr_done;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_en, ir_write, mem_write, reg_write,
    output iord, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src,
    output instr_done, illegal_op, state
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_en, ir_write, mem_write, reg_write,
    input  iord, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src,
    input  instr_done, illegal_op, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore-style control sequencer for the multicycle MIPS datapath.
// The sequencer handles one instruction at a time. Memory states stall on
// mem_ready. Opcodes it does not support are flagged with a one-cycle
// illegal_op pulse, and the sequencer then returns to FETCH.
module multicycle_ctrl #(
  parameter bit         MEM_WAIT_EN = 1'b1,
  parameter logic [5:0] OP_RTYPE    = 6'b000000,
  parameter logic [5:0] OP_LW       = 6'b100011,
  parameter logic [5:0] OP_SW       = 6'b101011,
  parameter logic [5:0] OP_BEQ      = 6'b000100,
  parameter logic [5:0] OP_ADDI     = 6'b001000,
  parameter logic [5:0] OP_J        = 6'b000010
) (
  input  logic              clk,
  input  logic              rst_n,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXEC     = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  state_t state_q, state_d;

  // With wait states disabled, every memory access completes in one cycle.
  logic mem_rdy;
  assign mem_rdy = MEM_WAIT_EN ? bus.mem_ready : 1'b1;

  // The enables and pulses are first decoded from state. They are then gated
  // with rst_n, so that no write can escape while reset is held.
  logic pc_en_raw, ir_write_raw, mem_write_raw, reg_write_raw;
  logic instr_done_raw, illegal_op_raw;

  // State register. Reset sends the sequencer back to FETCH, and any
  // instruction in progress is aborted.
  // NOTE: the asynchronous reset appears in the sensitivity list, and the state
  // uses non-blocking assignment, so every flop updates from the same
  // pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state and output decode from the current state. Only the memory
  // enables, the handshake-gated enables and the branch pc_en look at inputs.
  // NOTE: every output gets a default first, so each path assigns it and no
  // latch is inferred.
  always_comb begin
    state_d        = state_q;
    pc_en_raw      = 1'b0;
    ir_write_raw   = 1'b0;
    mem_write_raw  = 1'b0;
    reg_write_raw  = 1'b0;
    instr_done_raw = 1'b0;
    illegal_op_raw = 1'b0;
    bus.iord       = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.alu_op     = 2'b00;
    bus.pc_src     = 2'b00;

    case (state_q)
      S_FETCH: begin
        bus.alu_src_b = 2'b01;           // PC + 4
        ir_write_raw  = mem_rdy;
        pc_en_raw     = mem_rdy;
        if (mem_rdy) state_d = S_DECODE;
      end
      S_DECODE: begin
        bus.alu_src_b = 2'b11;           // Compute the branch target ahead of time.
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d        = S_FETCH;
            illegal_op_raw = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        // The IR still holds the opcode, so it is safe to steer on it again.
        state_d = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        bus.iord = 1'b1;
        if (mem_rdy) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        bus.mem_to_reg = 1'b1;
        reg_write_raw  = 1'b1;
        instr_done_raw = 1'b1;
        state_d        = S_FETCH;
      end
      S_MEMWR: begin
        bus.iord      = 1'b1;
        mem_write_raw = 1'b1;            // Stays asserted for the whole stall.
        if (mem_rdy) begin
          instr_done_raw = 1'b1;
          state_d        = S_FETCH;
        end
      end
      S_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 2'b10;
        state_d       = S_ALUWB;
      end
      S_ALUWB: begin
        bus.reg_dst    = 1'b1;
        reg_write_raw  = 1'b1;
        instr_done_raw = 1'b1;
        state_d        = S_FETCH;
      end
      S_BRANCH: begin
        bus.alu_src_a  = 1'b1;
        bus.alu_op     = 2'b01;
        bus.pc_src     = 2'b01;
        pc_en_raw      = bus.zero;
        instr_done_raw = 1'b1;
        state_d        = S_FETCH;
      end
      S_ADDIEXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        state_d       = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write_raw  = 1'b1;
        instr_done_raw = 1'b1;
        state_d        = S_FETCH;
      end
      S_JUMP: begin
        bus.pc_src     = 2'b10;
        pc_en_raw      = 1'b1;
        instr_done_raw = 1'b1;
        state_d        = S_FETCH;
      end
      default: state_d = S_FETCH;        // Encodings 12-15: all outputs idle.
    endcase
  end

  assign bus.pc_en      = pc_en_raw      & rst_n;
  assign bus.ir_write   = ir_write_raw   & rst_n;
  assign bus.mem_write  = mem_write_raw  & rst_n;
  assign bus.reg_write  = reg_write_raw  & rst_n;
  assign bus.instr_done = instr_done_raw & rst_n;
  assign bus.illegal_op = illegal_op_raw & rst_n;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl. Each instruction scenario queues per-cycle
// stimulus together with the expected state and outputs. The queue is then
// drained one clock at a time, and each entry is compared with the DUT.
module tb_multicycle_ctrl;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  logic clk = 1'b0;
  logic rst_n;

  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // we = {pc_en, ir_write, mem_write, reg_write}
  // sel = {iord, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src}
  typedef struct packed {
    logic [3:0] st;
    logic [3:0] we;
    logic       done;
    logic       ill;
    logic [9:0] sel;
  } exp_t;

  typedef struct packed {
    logic mr;
    logic z;
  } stim_t;

  exp_t  exp_q[$];
  stim_t stim_q[$];

  // Mux selects expected in each state, taken from the state table.
  function automatic logic [9:0] sel_of(input logic [3:0] st);
    case (st)
      4'd0:    return 10'b0_0_0_0_01_00_00;
      4'd1:    return 10'b0_0_0_0_11_00_00;
      4'd2:    return 10'b0_0_0_1_10_00_00;
      4'd3:    return 10'b1_0_0_0_00_00_00;
      4'd4:    return 10'b0_0_1_0_00_00_00;
      4'd5:    return 10'b1_0_0_0_00_00_00;
      4'd6:    return 10'b0_0_0_1_00_10_00;
      4'd7:    return 10'b0_1_0_0_00_00_00;
      4'd8:    return 10'b0_0_0_1_00_01_01;
      4'd9:    return 10'b0_0_0_1_10_00_00;
      4'd10:   return 10'b0_0_0_0_00_00_00;
      4'd11:   return 10'b0_0_0_0_00_00_10;
      default: return 10'b0;
    endcase
  endfunction

  function automatic logic [3:0] obs_we();
    return {bus.pc_en, bus.ir_write, bus.mem_write, bus.reg_write};
  endfunction

  function automatic logic [9:0] obs_sel();
    return {bus.iord, bus.reg_dst, bus.mem_to_reg, bus.alu_src_a,
            bus.alu_src_b, bus.alu_op, bus.pc_src};
  endfunction

  task automatic push(input logic [3:0] st, input logic [3:0] we,
                      input logic done, input logic ill,
                      input logic mr, input logic z);
    exp_t e;
    stim_t s;
    e.st = st; e.we = we; e.done = done; e.ill = ill; e.sel = sel_of(st);
    s.mr = mr; s.z = z;
    exp_q.push_back(e);
    stim_q.push_back(s);
  endtask

  // Run the queued cycles. The task starts and ends just after a rising edge.
  // It also checks the instruction length, the number of done pulses and the
  // return to FETCH.
  task automatic drain(input string name, input int cpi, input int n_done);
    int cyc = 0;
    int end_cyc = -1;
    int dones = 0;
    stim_t s;
    exp_t e;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      bus.mem_ready = s.mr;
      bus.zero      = s.z;
      @(negedge clk);
      e = exp_q.pop_front();
      cyc++;
      checks++;
      if (bus.state !== e.st) begin
        failures++;
        $display("FAIL %s cyc%0d state: got %0d exp %0d", name, cyc, bus.state, e.st);
      end
      checks++;
      if (obs_we() !== e.we) begin
        failures++;
        $display("FAIL %s cyc%0d write_enables: got %b exp %b", name, cyc, obs_we(), e.we);
      end
      checks++;
      if ({bus.instr_done, bus.illegal_op} !== {e.done, e.ill}) begin
        failures++;
        $display("FAIL %s cyc%0d done_illegal: got %b%b exp %b%b", name, cyc,
                 bus.instr_done, bus.illegal_op, e.done, e.ill);
      end
      checks++;
      if (obs_sel() !== e.sel) begin
        failures++;
        $display("FAIL %s cyc%0d selects: got %b exp %b", name, cyc, obs_sel(), e.sel);
      end
      if ((bus.instr_done === 1'b1 || bus.illegal_op === 1'b1) && end_cyc < 0) end_cyc = cyc;
      if (bus.instr_done === 1'b1) dones++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (end_cyc != cpi) begin
      failures++;
      $display("FAIL %s cycles: got %0d exp %0d", name, end_cyc, cpi);
    end
    checks++;
    if (dones != n_done) begin
      failures++;
      $display("FAIL %s done_pulses: got %0d exp %0d", name, dones, n_done);
    end
    checks++;
    if (bus.state !== 4'd0) begin
      failures++;
      $display("FAIL %s back_to_fetch: got %0d exp 0", name, bus.state);
    end
  endtask

  // Build the expected cycle trace of one instruction and run it.
  task automatic run_instr(input string name, input logic [5:0] op, input logic z,
                           input int fstall, input int mstall, input int cpi);
    bit legal;
    legal = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
            (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    bus.opcode = op;
    for (int i = 0; i < fstall; i++) push(4'd0, 4'b0000, 1'b0, 1'b0, 1'b0, z);
    push(4'd0, 4'b1100, 1'b0, 1'b0, 1'b1, z);
    push(4'd1, 4'b0000, 1'b0, !legal, 1'b0, z);
    if (op == OP_RTYPE) begin
      push(4'd6, 4'b0000, 1'b0, 1'b0, 1'b0, z);
      push(4'd7, 4'b0001, 1'b1, 1'b0, 1'b0, z);
    end else if (op == OP_LW) begin
      push(4'd2, 4'b0000, 1'b0, 1'b0, 1'b0, z);
      for (int i = 0; i < mstall; i++) push(4'd3, 4'b0000, 1'b0, 1'b0, 1'b0, z);
      push(4'd3, 4'b0000, 1'b0, 1'b0, 1'b1, z);
      push(4'd4, 4'b0001, 1'b1, 1'b0, 1'b0, z);
    end else if (op == OP_SW) begin
      push(4'd2, 4'b0000, 1'b0, 1'b0, 1'b0, z);
      for (int i = 0; i < mstall; i++) push(4'd5, 4'b0010, 1'b0, 1'b0, 1'b0, z);
      push(4'd5, 4'b0010, 1'b1, 1'b0, 1'b1, z);
    end else if (op == OP_BEQ) begin
      push(4'd8, {z, 3'b000}, 1'b1, 1'b0, 1'b0, z);
    end else if (op == OP_ADDI) begin
      push(4'd9, 4'b0000, 1'b0, 1'b0, 1'b0, z);
      push(4'd10, 4'b0001, 1'b1, 1'b0, 1'b0, z);
    end else if (op == OP_J) begin
      push(4'd11, 4'b1000, 1'b1, 1'b0, 1'b0, z);
    end
    drain(name, cpi, legal ? 1 : 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.opcode = OP_RTYPE;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b1;               // Would enable the fetch writes if reset leaked.
    repeat (2) @(negedge clk);
    checks++;
    if (bus.state !== 4'd0) begin
      failures++;
      $display("FAIL reset state: got %0d exp 0", bus.state);
    end
    checks++;
    if (obs_we() !== 4'b0000) begin
      failures++;
      $display("FAIL reset write_enables: got %b exp 0000", obs_we());
    end
    checks++;
    if ({bus.instr_done, bus.illegal_op} !== 2'b00) begin
      failures++;
      $display("FAIL reset done_illegal: got %b%b exp 00", bus.instr_done, bus.illegal_op);
    end
    checks++;
    if (obs_sel() !== sel_of(4'd0)) begin
      failures++;
      $display("FAIL reset selects: got %b exp %b", obs_sel(), sel_of(4'd0));
    end
    bus.mem_ready = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.state !== 4'd0) begin
      failures++;
      $display("FAIL reset_release_hold state: got %0d exp 0", bus.state);
    end
  endtask

  task automatic test_rtype();
    run_instr("rtype", OP_RTYPE, 1'b0, 0, 0, 4);
  endtask

  task automatic test_lw_stall();
    run_instr("lw_stall", OP_LW, 1'b0, 2, 3, 10);
    run_instr("lw_nostall", OP_LW, 1'b1, 0, 0, 5);
  endtask

  task automatic test_branch();
    run_instr("beq_taken", OP_BEQ, 1'b1, 0, 0, 3);
    run_instr("beq_not_taken", OP_BEQ, 1'b0, 0, 0, 3);
  endtask

  task automatic test_jump_addi();
    run_instr("jump", OP_J, 1'b0, 0, 0, 3);
    run_instr("addi", OP_ADDI, 1'b0, 0, 0, 4);
  endtask

  task automatic test_illegal();
    run_instr("illegal_3f", 6'b111111, 1'b0, 0, 0, 2);
    run_instr("illegal_01", 6'b000001, 1'b1, 1, 0, 3);
  endtask

  task automatic test_back_to_back();
    run_instr("b2b_sw", OP_SW, 1'b0, 0, 0, 4);
    run_instr("b2b_sw_stall", OP_SW, 1'b0, 1, 2, 7);
    run_instr("b2b_addi", OP_ADDI, 1'b1, 0, 0, 4);
    run_instr("b2b_rtype", OP_RTYPE, 1'b1, 0, 0, 4);
  endtask

  task automatic test_reset_abort();
    bus.opcode = OP_SW;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b1;
    repeat (3) begin                    // FETCH -> DECODE -> MEMADR -> MEMWR
      @(posedge clk);
      #1;
    end
    bus.mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.state !== 4'd5 || bus.mem_write !== 1'b1) begin
      failures++;
      $display("FAIL abort_pre state/mem_write: got %0d/%b exp 5/1", bus.state, bus.mem_write);
    end
    #2;
    rst_n = 1'b0;
    bus.mem_ready = 1'b1;
    #1;
    checks++;
    if (bus.mem_write !== 1'b0) begin
      failures++;
      $display("FAIL abort mem_write: got %b exp 0", bus.mem_write);
    end
    checks++;
    if (bus.state !== 4'd0) begin
      failures++;
      $display("FAIL abort state: got %0d exp 0", bus.state);
    end
    checks++;
    if (obs_we() !== 4'b0000) begin
      failures++;
      $display("FAIL abort write_enables: got %b exp 0000", obs_we());
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.state !== 4'd0) begin
      failures++;
      $display("FAIL abort_hold state: got %0d exp 0", bus.state);
    end
    bus.mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_instr("after_abort_rtype", OP_RTYPE, 1'b0, 0, 0, 4);
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_stall();
    test_branch();
    test_jump_addi();
    test_illegal();
    test_back_to_back();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore-style sequencer for the multicycle MIPS datapath.
- Drives every datapath mux select and write enable, one instruction at a time:
  - 3-input 32-bit PC-source mux.
  - 5-bit register-destination mux.
  - 2:1 32-bit muxes for IorD, ALU-A and MemtoReg.
- Stalls on a memory-ready handshake.
- Flags unsupported opcodes.

Parameters:
- MEM_WAIT_EN, 1, 1 = honour mem_ready in FETCH/MEMRD/MEMWR; 0 = treat mem_ready as always 1.
- OP_RTYPE, 6'b000000, R-type opcode.
- OP_LW, 6'b100011, load word.
- OP_SW, 6'b101011, store word.
- OP_BEQ, 6'b000100, branch equal.
- OP_ADDI, 6'b001000, add immediate.
- OP_J, 6'b000010, jump.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- opcode  input  6  IR[31:26], sampled in DECODE.
- zero  input  1  ALU zero flag.
- mem_ready  input  1  memory access completes this cycle.
- pc_en  output  1  PC register load enable.
- ir_write  output  1  instruction register load.
- mem_write  output  1  memory write strobe.
- reg_write  output  1  register file write.
- iord  output  1  address mux select: 0 = PC, 1 = ALUOut.
- reg_dst  output  1  5-bit dest mux select: 0 = rt, 1 = rd.
- mem_to_reg  output  1  writeback mux select: 0 = ALUOut, 1 = MDR.
- alu_src_a  output  1  0 = PC, 1 = regA.
- alu_src_b  output  2  00 = regB, 01 = const 4, 10 = signimm, 11 = signimm<<2.
- alu_op  output  2  00 = add, 01 = sub, 10 = decode funct.
- pc_src  output  2  00 = ALUResult, 01 = ALUOut, 1x = jump target (sel[1] has priority).
- instr_done  output  1  one-cycle pulse on an instruction's final cycle.
- illegal_op  output  1  one-cycle pulse on an unsupported opcode.
- state  output  4  current state, for debug.

Behaviour:
- State register is 4 bits, updated on the clk rising edge.
- rst_n low forces state = FETCH (0) immediately.
- While rst_n is low, all write enables are 0: pc_en, ir_write, mem_write, reg_write.
- Other outputs during reset take their FETCH values; instr_done = 0, illegal_op = 0.
- Reset mid-instruction aborts it with no further writes.
- Outputs decode from the current state. Only pc_en (BRANCH) and the mem_ready-gated enables are combinational on inputs.
- Any output not listed for a state is 0.
- State encodings and behaviour:
  - FETCH=0: iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00; ir_write = pc_en = mem_ready. mem_ready=1 -> DECODE, else hold.
  - DECODE=1: alu_src_a=0, alu_src_b=11, alu_op=00 (precompute branch target). Next state by opcode:
    - lw/sw -> MEMADR.
    - R-type -> EXEC.
    - beq -> BRANCH.
    - addi -> ADDIEXEC.
    - j -> JUMP.
    - any other opcode -> FETCH with illegal_op=1.
  - MEMADR=2: alu_src_a=1, alu_src_b=10, alu_op=00. -> MEMRD if opcode=lw, else MEMWR. Opcode must be held stable from the IR.
  - MEMRD=3: iord=1. mem_ready=1 -> MEMWB, else hold.
  - MEMWB=4: reg_dst=0, mem_to_reg=1, reg_write=1, instr_done=1. -> FETCH.
  - MEMWR=5: iord=1, mem_write=1 (held through the stall). mem_ready=1 -> FETCH with instr_done=1, else hold.
  - EXEC=6: alu_src_a=1, alu_src_b=00, alu_op=10. -> ALUWB.
  - ALUWB=7: reg_dst=1, mem_to_reg=0, reg_write=1, instr_done=1. -> FETCH.
  - BRANCH=8: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_en=zero, instr_done=1. -> FETCH.
  - ADDIEXEC=9: alu_src_a=1, alu_src_b=10, alu_op=00. -> ADDIWB.
  - ADDIWB=10: reg_dst=0, mem_to_reg=0, reg_write=1, instr_done=1. -> FETCH.
  - JUMP=11: pc_src=10, pc_en=1, instr_done=1. -> FETCH.
  - Encodings 12-15 are unreachable: all outputs 0, next state FETCH.
- Cycles per instruction, with zero wait states:
  - lw 5; sw 4; R-type 4; addi 4; beq 3; j 3; illegal 2.
  - Each stall cycle in FETCH, MEMRD or MEMWR adds 1.
- instr_done and illegal_op are never both high.
- illegal_op never coincides with any write enable.

Test Plan:
- Reset, then R-type (opcode 0), mem_ready=1 throughout -> states 0,1,6,7,0. reg_write=1, reg_dst=1 only in state 7. instr_done pulses once. Total 4 cycles.
- lw with mem_ready low for 2 cycles in FETCH and 3 cycles in MEMRD -> 10 cycles total. ir_write exactly once. mem_to_reg=1 and reg_write=1 in state 4 only.
- beq with zero=1 then zero=0 -> pc_en=1 with pc_src=01 in state 8 for the first; pc_en=0 for the second. Each instruction takes 3 cycles.
- j -> pc_src=10, pc_en=1 in state 11. addi -> reg_dst=0, mem_to_reg=0 in state 10.
- Opcode 6'b111111 -> illegal_op=1 for one cycle in DECODE, no write enables, back to FETCH on the next edge.
- sw stalled in MEMWR (mem_ready=0): assert rst_n=0 asynchronously mid-cycle -> mem_write drops immediately and state=0. After release, a normal fetch resumes.
